proc_mem_arb: RTL and testbench

- Arbiter and sequencer that shares one single-ported, val/rdy memory between the processor's instruction-fetch port and data port.
- Sits between the processor core and the unified memory.
- Issues at most one outstanding transaction and routes each response back to its owner.
- Default policy is fixed data-priority with an anti-starvation override for fetch.

---
 rtl/proc_mem_arb_pkg.sv | 16 +
 rtl/proc_mem_arb_starve.sv | 28 ++
 rtl/proc_mem_arb.sv | 136 +++++++++++++
 tb/tb_proc_mem_arb.sv | 333 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/proc_mem_arb_pkg.sv
// Shared types and constants for the processor/memory arbiter.
//   state_t : arbiter FSM states
//   owner_t : who holds (or is being granted) the memory port
//   MEMREQ_READ / MEMREQ_WRITE : memreq_type encodings
//   STARVE_W : width of the fetch starvation counter (covers MAX_WAIT 1..15)
package proc_mem_arb_pkg;

   typedef enum logic [1:0] {IDLE, WAIT_I, WAIT_D} state_t;
   typedef enum logic [1:0] {NONE, I, D}           owner_t;

   localparam logic MEMREQ_READ  = 1'b0;
   localparam logic MEMREQ_WRITE = 1'b1;

   localparam int STARVE_W = 4;

endpackage

// File: rtl/proc_mem_arb_starve.sv
// Saturating fetch-starvation counter.
//   clk, rst : clock, asynchronous active-low reset
//   inc      : count one lost arbitration (holds once saturated)
//   clr      : clear (wins over inc)
//   sat      : counter has reached MAX_WAIT
module proc_mem_arb_starve
   import proc_mem_arb_pkg::*;
#(
   parameter int MAX_WAIT = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic inc,
   input  logic clr,
   output logic sat
);

   logic [STARVE_W-1:0] cnt;

   assign sat = (cnt == STARVE_W'(MAX_WAIT));

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)             cnt <= '0;
      else if (clr)         cnt <= '0;
      else if (inc && !sat) cnt <= cnt + 1'b1;
   end

endmodule

// File: rtl/proc_mem_arb.sv
// Shares one single-ported val/rdy memory between the instruction-fetch
// port (I) and the data port (D). One transaction outstanding at a time;
// the response is passed straight through to whichever port issued it.
//
// Ports:
//   clk, rst                      clock, asynchronous active-low reset
//   imemreq_*  / imemresp_*       fetch request / response
//   dmemreq_*  / dmemresp_*       data request / response
//   memreq_*   / memresp_*        unified memory request / response
//   err                           sticky: response arrived with nothing outstanding
//
// Build option PROC_MEM_ARB_RR_EN: round-robin between I and D instead of
// fixed data priority; the starvation counter is then not built.
module proc_mem_arb
   import proc_mem_arb_pkg::*;
#(
   parameter int MAX_WAIT = 4,
   parameter int AW       = 32,
   parameter int DW       = 32
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          imemreq_val,
   output logic          imemreq_rdy,
   input  logic [AW-1:0] imemreq_addr,
   output logic          imemresp_val,
   output logic [DW-1:0] imemresp_data,
   input  logic          dmemreq_val,
   output logic          dmemreq_rdy,
   input  logic          dmemreq_type,
   input  logic [AW-1:0] dmemreq_addr,
   input  logic [DW-1:0] dmemreq_wdata,
   output logic          dmemresp_val,
   output logic [DW-1:0] dmemresp_rdata,
   output logic          memreq_val,
   input  logic          memreq_rdy,
   output logic          memreq_type,
   output logic [AW-1:0] memreq_addr,
   output logic [DW-1:0] memreq_wdata,
   input  logic          memresp_val,
   input  logic [DW-1:0] memresp_data,
   output logic          err
);

   state_t state;
   owner_t owner;
   owner_t grant;
   logic   armed;   // low for the first cycle after reset so no request leaks out
   logic   issue;

`ifdef PROC_MEM_ARB_RR_EN
   owner_t last_grant;

   always_comb begin
      grant = NONE;
      if (armed && state == IDLE) begin
         if (imemreq_val && dmemreq_val) grant = (last_grant == I) ? D : I;
         else if (dmemreq_val)           grant = D;
         else if (imemreq_val)           grant = I;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)       last_grant <= I;
      else if (issue) last_grant <= grant;
   end
`else
   logic starve_sat;

   // Each D issue that a waiting fetch loses counts against the fetch.
   proc_mem_arb_starve #(.MAX_WAIT(MAX_WAIT)) u_starve (
      .clk (clk),
      .rst (rst),
      .inc (dmemreq_rdy && imemreq_val),
      .clr (imemreq_rdy),
      .sat (starve_sat)
   );

   always_comb begin
      grant = NONE;
      if (armed && state == IDLE) begin
         if (starve_sat && imemreq_val) grant = I;
         else if (dmemreq_val)          grant = D;
         else if (imemreq_val)          grant = I;
      end
   end
`endif

   // Request mux; grant is already NONE outside IDLE.
   assign memreq_val   = (grant != NONE);
   assign memreq_type  = (grant == D) ? dmemreq_type  : MEMREQ_READ;
   assign memreq_addr  = (grant == D) ? dmemreq_addr  : imemreq_addr;
   assign memreq_wdata = (grant == D) ? dmemreq_wdata : '0;

   assign imemreq_rdy  = (grant == I) && memreq_rdy;
   assign dmemreq_rdy  = (grant == D) && memreq_rdy;
   assign issue        = imemreq_rdy || dmemreq_rdy;

   // Response pass-through to the recorded owner.
   assign imemresp_val   = memresp_val && (state == WAIT_I) && (owner == I);
   assign dmemresp_val   = memresp_val && (state == WAIT_D) && (owner == D);
   assign imemresp_data  = memresp_data;
   assign dmemresp_rdata = memresp_data;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= IDLE;
         owner <= NONE;
         err   <= 1'b0;
         armed <= 1'b0;
      end else begin
         armed <= 1'b1;
         case (state)
            IDLE: begin
               // A response here belongs to nothing (e.g. abandoned by reset).
               if (memresp_val) err <= 1'b1;
               if (issue) begin
                  state <= (grant == I) ? WAIT_I : WAIT_D;
                  owner <= grant;
               end
            end
            WAIT_I, WAIT_D: begin
               if (memresp_val) begin
                  state <= IDLE;
                  owner <= NONE;
               end
            end
            default: begin
               state <= IDLE;
               owner <= NONE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_proc_mem_arb.sv
// Scoreboard bench for proc_mem_arb. Stimulus pushes requests into per-port
// driver queues and the expected memory-side/response-side events into exp_q;
// a monitor pops exp_q on every observed handshake or response.
// Memory model: responds one cycle after each handshake with mem_data(addr).
module tb_proc_mem_arb;

   typedef struct packed {
      logic        is_resp;
      logic        port_d;
      logic        wr;
      logic        chk;
      logic [31:0] addr;
      logic [31:0] data;
   } ev_t;

   typedef struct packed {
      logic        wr;
      logic [31:0] addr;
      logic [31:0] wdata;
   } dreq_t;

   logic        clk, rst;
   logic        imemreq_val, imemreq_rdy;
   logic [31:0] imemreq_addr;
   logic        imemresp_val;
   logic [31:0] imemresp_data;
   logic        dmemreq_val, dmemreq_rdy, dmemreq_type;
   logic [31:0] dmemreq_addr, dmemreq_wdata;
   logic        dmemresp_val;
   logic [31:0] dmemresp_rdata;
   logic        memreq_val, memreq_rdy, memreq_type;
   logic [31:0] memreq_addr, memreq_wdata;
   logic        memresp_val;
   logic [31:0] memresp_data;
   logic        err;

   int n_vec = 0;
   int n_err = 0;

   ev_t         exp_q[$];
   logic [31:0] i_q[$];
   dreq_t       d_q[$];

   logic        mem_auto = 1'b1;
   int          stale_req = 0;
   int          stale_done = 0;
   logic        mhs;
   logic [31:0] mha;
   logic        i_acc, d_acc;

   proc_mem_arb #(.MAX_WAIT(4), .AW(32), .DW(32)) dut (
      .clk(clk), .rst(rst),
      .imemreq_val(imemreq_val), .imemreq_rdy(imemreq_rdy), .imemreq_addr(imemreq_addr),
      .imemresp_val(imemresp_val), .imemresp_data(imemresp_data),
      .dmemreq_val(dmemreq_val), .dmemreq_rdy(dmemreq_rdy), .dmemreq_type(dmemreq_type),
      .dmemreq_addr(dmemreq_addr), .dmemreq_wdata(dmemreq_wdata),
      .dmemresp_val(dmemresp_val), .dmemresp_rdata(dmemresp_rdata),
      .memreq_val(memreq_val), .memreq_rdy(memreq_rdy), .memreq_type(memreq_type),
      .memreq_addr(memreq_addr), .memreq_wdata(memreq_wdata),
      .memresp_val(memresp_val), .memresp_data(memresp_data),
      .err(err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic logic [31:0] mem_data(input logic [31:0] a);
      return (a == 32'h0000_0010) ? 32'hDEAD_BEEF : (a ^ 32'h5A5A_0000);
   endfunction

   function automatic void ex_req(input logic d, input logic wr, input logic [31:0] a,
                                  input logic [31:0] wd);
      ev_t e;
      e = '0; e.port_d = d; e.wr = wr; e.addr = a; e.data = wd;
      exp_q.push_back(e);
   endfunction

   function automatic void ex_rsp(input logic d, input logic chk, input logic [31:0] dat);
      ev_t e;
      e = '0; e.is_resp = 1'b1; e.port_d = d; e.chk = chk; e.data = dat;
      exp_q.push_back(e);
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
      n_vec++;
      if (act !== req) begin
         n_err++;
         $display("FAIL %s: got %h, required %h", nm, act, req);
      end
   endtask

   task automatic check_ev(input ev_t a, input string nm);
      ev_t  e;
      logic bad;
      n_vec++;
      if (exp_q.size() == 0) begin
         n_err++;
         $display("FAIL unexpected_%s: got port_d=%0b addr=%h data=%h, required no event",
                  nm, a.port_d, a.addr, a.data);
         return;
      end
      e = exp_q.pop_front();
      bad = (a.is_resp != e.is_resp) || (a.port_d != e.port_d);
      if (!e.is_resp) bad = bad || (a.wr != e.wr) || (a.addr != e.addr) || (e.wr && a.data != e.data);
      else            bad = bad || (e.chk && a.data != e.data);
      if (bad) begin
         n_err++;
         $display("FAIL %s: got resp=%0b port_d=%0b wr=%0b addr=%h data=%h, required resp=%0b port_d=%0b wr=%0b addr=%h data=%h",
                  nm, a.is_resp, a.port_d, a.wr, a.addr, a.data,
                  e.is_resp, e.port_d, e.wr, e.addr, e.data);
      end
   endtask

   // Monitor: every handshake and every response is one scoreboard event.
   initial begin
      ev_t  a;
      logic hs;
      forever begin
         @(negedge clk);
         hs = memreq_val && memreq_rdy;
         if (hs) begin
            chk("one_rdy", {31'd0, imemreq_rdy ^ dmemreq_rdy}, 32'd1);
            a = '0; a.port_d = dmemreq_rdy; a.wr = memreq_type;
            a.addr = memreq_addr; a.data = memreq_wdata;
            check_ev(a, "req");
         end
         if (imemresp_val || dmemresp_val) begin
            chk("no_issue_in_resp_cycle", {31'd0, hs}, 32'd0);
            chk("one_resp", {31'd0, imemresp_val && dmemresp_val}, 32'd0);
         end
         if (imemresp_val) begin
            a = '0; a.is_resp = 1'b1; a.data = imemresp_data;
            check_ev(a, "iresp");
         end
         if (dmemresp_val) begin
            a = '0; a.is_resp = 1'b1; a.port_d = 1'b1; a.data = dmemresp_rdata;
            check_ev(a, "dresp");
         end
      end
   end

   // Memory model: one-cycle latency, plus injected stale responses.
   initial begin
      memresp_val = 1'b0; memresp_data = '0;
      forever begin
         @(negedge clk);
         mhs = memreq_val && memreq_rdy;
         mha = memreq_addr;
         @(posedge clk); #1;
         memresp_val = 1'b0;
         if (stale_req != stale_done) begin
            memresp_val = 1'b1; memresp_data = 32'hBAD0_BAD0; stale_done++;
         end else if (mhs && mem_auto) begin
            memresp_val = 1'b1; memresp_data = mem_data(mha);
         end
      end
   end

   // Fetch driver: presents the head of i_q, pops on accept.
   initial begin
      imemreq_val = 1'b0; imemreq_addr = '0;
      forever begin
         @(negedge clk);
         i_acc = imemreq_val && imemreq_rdy;
         @(posedge clk); #1;
         if (i_acc) void'(i_q.pop_front());
         if (i_q.size() != 0) begin imemreq_val = 1'b1; imemreq_addr = i_q[0]; end
         else                 begin imemreq_val = 1'b0; imemreq_addr = '0; end
      end
   end

   // Data driver.
   initial begin
      dmemreq_val = 1'b0; dmemreq_type = 1'b0; dmemreq_addr = '0; dmemreq_wdata = '0;
      forever begin
         @(negedge clk);
         d_acc = dmemreq_val && dmemreq_rdy;
         @(posedge clk); #1;
         if (d_acc) void'(d_q.pop_front());
         if (d_q.size() != 0) begin
            dmemreq_val = 1'b1; dmemreq_type = d_q[0].wr;
            dmemreq_addr = d_q[0].addr; dmemreq_wdata = d_q[0].wdata;
         end else begin
            dmemreq_val = 1'b0; dmemreq_type = 1'b0; dmemreq_addr = '0; dmemreq_wdata = '0;
         end
      end
   end

   task automatic drain();
      int t = 0;
      while (exp_q.size() != 0 && t < 300) begin
         @(posedge clk);
         t++;
      end
      if (exp_q.size() != 0) begin
         n_vec++; n_err++;
         $display("FAIL drain_timeout: got %0d events outstanding, required 0", exp_q.size());
         exp_q.delete();
      end
      repeat (2) @(posedge clk);
      #2;
   endtask

   task automatic push_d(input logic wr, input logic [31:0] a, input logic [31:0] wd);
      dreq_t r;
      r.wr = wr; r.addr = a; r.wdata = wd;
      d_q.push_back(r);
   endtask

   initial begin
      rst = 1'b0; memreq_rdy = 1'b1;

      // Reset with a fetch already waiting: nothing may leak out.
      i_q.push_back(32'h0000_0010);
      ex_req(1'b0, 1'b0, 32'h0000_0010, 32'h0);
      ex_rsp(1'b0, 1'b1, 32'hDEAD_BEEF);
      repeat (3) @(negedge clk);
      chk("rst_memreq_val",  {31'd0, memreq_val},   32'd0);
      chk("rst_imemreq_rdy", {31'd0, imemreq_rdy},  32'd0);
      chk("rst_err",         {31'd0, err},          32'd0);
      chk("rst_imemresp",    {31'd0, imemresp_val}, 32'd0);
      @(posedge clk); #2;
      rst = 1'b1;
      @(negedge clk);
      chk("post_rst_memreq_val",  {31'd0, memreq_val},  32'd0);
      chk("post_rst_imemreq_rdy", {31'd0, imemreq_rdy}, 32'd0);
      drain();

      // Data write alone.
      push_d(1'b1, 32'h0000_0100, 32'h1234_5678);
      ex_req(1'b1, 1'b1, 32'h0000_0100, 32'h1234_5678);
      ex_rsp(1'b1, 1'b0, 32'h0);
      drain();

`ifdef PROC_MEM_ARB_RR_EN
      // Fresh reset so last_grant is I: grants alternate starting with D.
      @(posedge clk); #2; rst = 1'b0;
      for (int k = 0; k < 3; k++) begin
         i_q.push_back(32'h0000_0600 + 32'(k * 4));
         push_d(1'b0, 32'h0000_0700 + 32'(k * 4), 32'h0);
      end
      for (int k = 0; k < 3; k++) begin
         ex_req(1'b1, 1'b0, 32'h0000_0700 + 32'(k * 4), 32'h0);
         ex_rsp(1'b1, 1'b1, 32'h5A5A_0700 + 32'(k * 4));
         ex_req(1'b0, 1'b0, 32'h0000_0600 + 32'(k * 4), 32'h0);
         ex_rsp(1'b0, 1'b1, 32'h5A5A_0600 + 32'(k * 4));
      end
      repeat (2) @(posedge clk); #2; rst = 1'b1;
      drain();
`else
      // Simultaneous: D wins, I follows on the next IDLE.
      @(negedge clk);
      push_d(1'b0, 32'h0000_0200, 32'h0);
      i_q.push_back(32'h0000_0014);
      ex_req(1'b1, 1'b0, 32'h0000_0200, 32'h0);
      ex_rsp(1'b1, 1'b1, 32'h5A5A_0200);
      ex_req(1'b0, 1'b0, 32'h0000_0014, 32'h0);
      ex_rsp(1'b0, 1'b1, 32'h5A5A_0014);
      drain();

      // Starvation: four D grants, then the fetch is forced through.
      @(negedge clk);
      for (int k = 0; k < 6; k++) push_d(1'b0, 32'h0000_0300 + 32'(k * 4), 32'h0);
      i_q.push_back(32'h0000_0040);
      for (int k = 0; k < 4; k++) begin
         ex_req(1'b1, 1'b0, 32'h0000_0300 + 32'(k * 4), 32'h0);
         ex_rsp(1'b1, 1'b1, 32'h5A5A_0300 + 32'(k * 4));
      end
      ex_req(1'b0, 1'b0, 32'h0000_0040, 32'h0);
      ex_rsp(1'b0, 1'b1, 32'h5A5A_0040);
      ex_req(1'b1, 1'b0, 32'h0000_0310, 32'h0);
      ex_rsp(1'b1, 1'b1, 32'h5A5A_0310);
      ex_req(1'b1, 1'b0, 32'h0000_0314, 32'h0);
      ex_rsp(1'b1, 1'b1, 32'h5A5A_0314);
      drain();
      chk("starve_cnt_cleared", {28'd0, dut.u_starve.cnt}, 32'd0);
`endif

      // Backpressure: request held stable until memreq_rdy returns.
      @(posedge clk); #2;
      memreq_rdy = 1'b0;
      i_q.push_back(32'h0000_0080);
      ex_req(1'b0, 1'b0, 32'h0000_0080, 32'h0);
      ex_rsp(1'b0, 1'b1, 32'h5A5A_0080);
      @(posedge clk); #2;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         chk("bp_memreq_val",  {31'd0, memreq_val},  32'd1);
         chk("bp_memreq_addr", memreq_addr,          32'h0000_0080);
         chk("bp_imemreq_rdy", {31'd0, imemreq_rdy}, 32'd0);
         @(posedge clk); #2;
      end
      memreq_rdy = 1'b1;
      @(negedge clk);
      chk("bp_first_rdy_hs", {31'd0, memreq_val && imemreq_rdy}, 32'd1);
      drain();
      chk("err_clean", {31'd0, err}, 32'd0);

      // Reset while a data read is outstanding; its late response is stale.
      mem_auto = 1'b0;
      push_d(1'b0, 32'h0000_0500, 32'h0);
      ex_req(1'b1, 1'b0, 32'h0000_0500, 32'h0);
      drain();
      rst = 1'b0;
      @(negedge clk);
      chk("midrst_memreq_val", {31'd0, memreq_val}, 32'd0);
      chk("midrst_err",        {31'd0, err},        32'd0);
      @(posedge clk); #2;
      rst = 1'b1;
      repeat (2) @(posedge clk); #2;
      stale_req++;
      repeat (3) @(posedge clk); #2;
      mem_auto = 1'b1;
      @(negedge clk);
      chk("stale_err", {31'd0, err}, 32'd1);

      i_q.push_back(32'h0000_0090);
      ex_req(1'b0, 1'b0, 32'h0000_0090, 32'h0);
      ex_rsp(1'b0, 1'b1, 32'h5A5A_0090);
      drain();
      chk("err_sticky", {31'd0, err}, 32'd1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
